// File: rtl/alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_seq
// Description : Registered MIPS ALU control decoder with multi-cycle op
//               sequencing. Single-cycle ops complete one cycle after accept.
//               MUL (and DIV when ALU_DIV_EN is defined) run a latency
//               counter and raise stall until the result cycle.
//               Optional feature macro: ALU_DIV_EN (Func 011010 -> div).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_seq #(
  parameter int CTRL_W  = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [1:0]        AluOP,
  input  logic [5:0]        Func,
  output logic [CTRL_W-1:0] Alu_Control,
  output logic              valid_out,
  output logic              stall,
  output logic              MultiCycle,
  output logic              Illegal_Func
);

  // Counter is sized for the longest configured latency; it only ever counts
  // down from LAT-2, so it never wraps.
  localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_CNT_W   = (c_MAX_LAT > 2) ? $clog2(c_MAX_LAT) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]         r_code, w_code_nxt;
  logic               r_valid_out, w_valid_out_nxt;
  logic               r_multi, w_multi_nxt;
  logic               r_illegal, w_illegal_nxt;

  logic [2:0]         w_dec_code;
  logic               w_dec_multi;
  logic               w_dec_illegal;
  logic [c_CNT_W-1:0] w_dec_load;
  logic               w_stall;
  logic               w_accept;

  assign w_stall   = (r_state == S_EXEC);
  assign w_accept  = valid_in & ~w_stall & ~flush;

  assign Alu_Control  = CTRL_W'(r_code);
  assign valid_out    = r_valid_out;
  assign stall        = w_stall;
  assign MultiCycle   = r_multi;
  assign Illegal_Func = r_illegal;

  // Combinational decode of AluOP/Func into code, multi-cycle flag and counter preload.
  always_comb begin
    w_dec_code    = 3'b010;
    w_dec_multi   = 1'b0;
    w_dec_illegal = 1'b0;
    w_dec_load    = '0;
    case (AluOP)
      2'b01: w_dec_code = 3'b100;
      2'b10: begin
        case (Func)
          6'b100000: w_dec_code = 3'b010;
          6'b100010: w_dec_code = 3'b100;
          6'b101010: w_dec_code = 3'b110;
          6'b100100: w_dec_code = 3'b000;
          6'b100101: w_dec_code = 3'b001;
          6'b011100: begin
            w_dec_code  = 3'b101;
            w_dec_multi = 1'b1;
            w_dec_load  = c_CNT_W'(MUL_LAT - 2);
          end
`ifdef ALU_DIV_EN
          6'b011010: begin
            w_dec_code  = 3'b111;
            w_dec_multi = 1'b1;
            w_dec_load  = c_CNT_W'(DIV_LAT - 2);
          end
`endif
          default: begin
            w_dec_code    = 3'b010;
            w_dec_illegal = 1'b1;
          end
        endcase
      end
      default: w_dec_code = 3'b010;
    endcase
  end

  // Next-state and next-output logic; flush overrides everything except the held code.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_code_nxt      = r_code;
    w_valid_out_nxt = 1'b0;
    w_multi_nxt     = 1'b0;
    w_illegal_nxt   = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_code_nxt = w_dec_code;
            if (w_dec_multi) begin
              w_state_nxt = S_EXEC;
              w_cnt_nxt   = w_dec_load;
            end else begin
              w_valid_out_nxt = 1'b1;
              w_illegal_nxt   = w_dec_illegal;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            w_state_nxt     = S_IDLE;
            w_valid_out_nxt = 1'b1;
            w_multi_nxt     = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_code      <= 3'b010;
      r_valid_out <= 1'b0;
      r_multi     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_code      <= w_code_nxt;
      r_valid_out <= w_valid_out_nxt;
      r_multi     <= w_multi_nxt;
      r_illegal   <= w_illegal_nxt;
    end
  end

endmodule
`default_nettype wire
